// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - ASCII command constants, command kinds, FSM states and byte decoder
package uart_cmd_pkg;

  localparam logic [7:0] CH_RUN  = 8'h72; // 'r'
  localparam logic [7:0] CH_CLR  = 8'h63; // 'c'
  localparam logic [7:0] CH_UP   = 8'h2B; // '+'
  localparam logic [7:0] CH_DN   = 8'h2D; // '-'
  localparam logic [7:0] CH_L    = 8'h4C; // 'L'
  localparam logic [7:0] CH_R    = 8'h52; // 'R'
  localparam logic [7:0] CH_CAL  = 8'h43; // 'C'
  localparam logic [7:0] CH_FMT  = 8'h46; // 'F'
  localparam logic [7:0] CH_SEL  = 8'h53; // 'S'
  localparam logic [7:0] CH_NAK  = 8'h3F; // '?'
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;

  typedef enum logic [3:0] {
    K_RUN, K_CLR, K_UP, K_DN, K_L, K_R, K_CAL, K_FMT, K_SEL, K_DIG, K_UNK
  } cmd_kind_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EMIT, S_GAP, S_DIGIT, S_REPLY
  } state_t;

  function automatic cmd_kind_t decode_cmd(input logic [7:0] b);
    cmd_kind_t k;
    case (b)
      CH_RUN:  k = K_RUN;
      CH_CLR:  k = K_CLR;
      CH_UP:   k = K_UP;
      CH_DN:   k = K_DN;
      CH_L:    k = K_L;
      CH_R:    k = K_R;
      CH_CAL:  k = K_CAL;
      CH_FMT:  k = K_FMT;
      CH_SEL:  k = K_SEL;
      default: k = (b >= CH_ZERO && b <= CH_NINE) ? K_DIG : K_UNK;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cmd_repeat_timer.sv
// rtl/cmd_repeat_timer.sv - remaining-pulse and inter-pulse gap counters for repeated commands
module cmd_repeat_timer #(
  parameter int GAP_CYC = 4,
  parameter int RW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [RW-1:0] load_rem,
  output logic          emit,
  output logic          done,
  output logic          gap_end
);

  localparam int GW = $clog2(GAP_CYC + 1);

  logic [RW-1:0] rem;
  logic [GW-1:0] gap;
  logic          active;

  // An emit fires whenever a burst is active and the gap has drained.
  assign emit    = active && (gap == '0);
  assign done    = emit && (rem == RW'(1));
  assign gap_end = (gap == GW'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem    <= '0;
      gap    <= '0;
      active <= 1'b0;
    end else if (load) begin
      rem    <= load_rem;
      gap    <= '0;
      active <= 1'b1;
    end else if (emit) begin
      rem <= rem - 1'b1;
      if (rem == RW'(1)) active <= 1'b0;
      else               gap    <= GW'(GAP_CYC);
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder_mc.sv
// rtl/uart_cmd_decoder_mc.sv - multi-channel ASCII command decoder with repeat prefix and echo
module uart_cmd_decoder_mc
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int REP_MAX = 15,
  parameter int GAP_CYC = 4,
  parameter int ECHO_EN = 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_rx_empty,
  input  logic [7:0]        rx_data,
  output logic              fifo_rx_pop,
  input  logic              fifo_tx_full,
  output logic              fifo_tx_push,
  output logic [7:0]        tx_data,
  output logic [CW-1:0]     ch_sel,
  output logic [NUM_CH-1:0] p_run,
  output logic [NUM_CH-1:0] p_clear,
  output logic [NUM_CH-1:0] p_up,
  output logic [NUM_CH-1:0] p_down,
  output logic [NUM_CH-1:0] p_left,
  output logic [NUM_CH-1:0] p_right,
  output logic [NUM_CH-1:0] calib_mode,
  output logic [NUM_CH-1:0] fmt_mode
);

  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [NUM_CH-1:0] ONE = 1;

  state_t        state;
  logic [7:0]    byte_q;
  cmd_kind_t     kind_q;
  logic [7:0]    reply_q;
  logic [RW-1:0] rep;

  cmd_kind_t     kind;
  logic          cal_cur;
  logic          is_rep;
  logic          illegal;
  logic          load;
  logic [RW-1:0] load_rem;
  logic          emit;
  logic          done;
  logic          gap_end;
  logic [NUM_CH-1:0] onehot;
  logic [CW-1:0]     ch_next;
  logic [RW+4:0]     rep_acc;
  logic [RW-1:0]     rep_sat;

  assign kind    = decode_cmd(byte_q);
  assign cal_cur = calib_mode[ch_sel];
  assign is_rep  = (kind == K_UP) || (kind == K_DN) || (kind == K_L) || (kind == K_R);
  assign illegal = (kind == K_UNK) || (is_rep && !cal_cur) ||
                   (((kind == K_RUN) || (kind == K_CLR)) && cal_cur);

  // Only pulse/toggle commands go through the timer; non-repeatables always fire once.
  assign load     = (state == S_DECODE) && !illegal &&
                    (kind != K_DIG) && (kind != K_SEL);
  assign load_rem = (is_rep && (rep != '0)) ? rep : RW'(1);

  assign onehot  = ONE << ch_sel;
  assign ch_next = (ch_sel == CW'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
  assign rep_acc = ((RW+5)'(rep) * (RW+5)'(10)) + (RW+5)'(byte_q[3:0]);
  assign rep_sat = (rep_acc > (RW+5)'(REP_MAX)) ? RW'(REP_MAX) : rep_acc[RW-1:0];

  cmd_repeat_timer #(
    .GAP_CYC (GAP_CYC),
    .RW      (RW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_rem (load_rem),
    .emit     (emit),
    .done     (done),
    .gap_end  (gap_end)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      byte_q       <= '0;
      kind_q       <= K_UNK;
      reply_q      <= '0;
      rep          <= '0;
      fifo_rx_pop  <= 1'b0;
      fifo_tx_push <= 1'b0;
      tx_data      <= '0;
      ch_sel       <= '0;
      p_run        <= '0;
      p_clear      <= '0;
      p_up         <= '0;
      p_down       <= '0;
      p_left       <= '0;
      p_right      <= '0;
      calib_mode   <= '0;
      fmt_mode     <= '0;
    end else begin
      fifo_rx_pop  <= 1'b0;
      fifo_tx_push <= 1'b0;
      p_run        <= '0;
      p_clear      <= '0;
      p_up         <= '0;
      p_down       <= '0;
      p_left       <= '0;
      p_right      <= '0;
      case (state)
        S_IDLE: begin
          if (!fifo_rx_empty) begin
            byte_q      <= rx_data;
            fifo_rx_pop <= 1'b1;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          kind_q <= kind;
          if (kind != K_DIG) rep <= '0;
          if (kind == K_DIG) begin
            state <= S_DIGIT;
          end else if (illegal) begin
            reply_q <= CH_NAK;
            state   <= S_REPLY;
          end else if (kind == K_SEL) begin
            ch_sel  <= ch_next;
            reply_q <= CH_ZERO + 8'(ch_next);
            state   <= S_REPLY;
          end else begin
            reply_q <= byte_q;
            state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          case (kind_q)
            K_RUN:   p_run      <= onehot;
            K_CLR:   p_clear    <= onehot;
            K_UP:    p_up       <= onehot;
            K_DN:    p_down     <= onehot;
            K_L:     p_left     <= onehot;
            K_R:     p_right    <= onehot;
            K_CAL:   calib_mode <= calib_mode ^ onehot;
            K_FMT:   fmt_mode   <= fmt_mode ^ onehot;
            default: ;
          endcase
          state <= (done || !emit) ? S_REPLY : S_GAP;
        end
        S_GAP: begin
          if (gap_end) state <= S_EMIT;
        end
        S_DIGIT: begin
          rep     <= rep_sat;
          reply_q <= byte_q;
          state   <= S_REPLY;
        end
        S_REPLY: begin
          // A stalled TX FIFO holds the FSM here, which in turn stalls RX popping.
          if (ECHO_EN == 0) begin
            state <= S_IDLE;
          end else if (!fifo_tx_full) begin
            fifo_tx_push <= 1'b1;
            tx_data      <= reply_q;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder_mc.sv
// tb/tb_uart_cmd_decoder_mc.sv - directed self-checking bench for uart_cmd_decoder_mc
module tb_uart_cmd_decoder_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_rx_empty;
  logic [7:0] rx_data;
  logic       fifo_rx_pop;
  logic       fifo_tx_full;
  logic       fifo_tx_push;
  logic [7:0] tx_data;
  logic [0:0] ch_sel;
  logic [1:0] p_run, p_clear, p_up, p_down, p_left, p_right;
  logic [1:0] calib_mode, fmt_mode;

  int tests = 0;
  int fails = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int pop_cyc[$];
  int pulse_cyc[$];
  int cyc = 0;
  int pop_cnt, run_cnt, up_cnt, down_cnt, viol;
  logic [1:0] run_or, up_or;

  uart_cmd_decoder_mc #(
    .NUM_CH(2), .REP_MAX(15), .GAP_CYC(4), .ECHO_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_rx_empty(fifo_rx_empty), .rx_data(rx_data), .fifo_rx_pop(fifo_rx_pop),
    .fifo_tx_full(fifo_tx_full), .fifo_tx_push(fifo_tx_push), .tx_data(tx_data),
    .ch_sel(ch_sel),
    .p_run(p_run), .p_clear(p_clear), .p_up(p_up), .p_down(p_down),
    .p_left(p_left), .p_right(p_right),
    .calib_mode(calib_mode), .fmt_mode(fmt_mode)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    fifo_rx_empty = (rxq.size() == 0);
    rx_data       = (rxq.size() == 0) ? 8'h00 : rxq[0];
  endtask

  // Show-ahead RX FIFO model plus an output monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    logic [11:0] allp;
    logic [1:0]  anyp;
    logic [1:0]  sel_mask;
    logic [7:0]  tmp;
    cyc++;
    if (fifo_rx_pop) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
      if (rxq.size() > 0) tmp = rxq.pop_front();
      refresh();
    end
    if (fifo_tx_push) txq.push_back(tx_data);
    allp     = {p_run, p_clear, p_up, p_down, p_left, p_right};
    anyp     = p_run | p_clear | p_up | p_down | p_left | p_right;
    sel_mask = 2'b01 << ch_sel;
    if (allp != '0) begin
      pulse_cyc.push_back(cyc);
      if ($countones(allp) != 1) viol++;
      if (anyp != sel_mask) viol++;
    end
    if (p_run != '0) run_cnt++;
    if (p_up != '0) up_cnt++;
    if (p_down != '0) down_cnt++;
    run_or = run_or | p_run;
    up_or  = up_or | p_up;
  end

  task automatic clear_logs();
    txq.delete();
    pop_cyc.delete();
    pulse_cyc.delete();
    pop_cnt = 0; run_cnt = 0; up_cnt = 0; down_cnt = 0;
    run_or = '0; up_or = '0;
  endtask

  task automatic push_bytes(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
    refresh();
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic string tx_str();
    string s = "";
    foreach (txq[i]) s = {s, string'(txq[i])};
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b0; fifo_tx_full = 1'b0;
    refresh();
    run(3);
    rst = 1'b1;
    run(2);
    clear_logs();
    viol = 0;
    tests++; if (fifo_rx_pop !== 1'b0) begin fails++; $display("FAIL reset_pop got %b want 0", fifo_rx_pop); end
    tests++; if (fifo_tx_push !== 1'b0) begin fails++; $display("FAIL reset_push got %b want 0", fifo_tx_push); end
    tests++; if (ch_sel !== 1'b0) begin fails++; $display("FAIL reset_ch_sel got %0d want 0", ch_sel); end
    tests++; if ({p_run, p_clear, p_up, p_down, p_left, p_right} !== 12'h000) begin
      fails++; $display("FAIL reset_pulses got %h want 000", {p_run, p_clear, p_up, p_down, p_left, p_right}); end
    tests++; if ({calib_mode, fmt_mode} !== 4'b0000) begin
      fails++; $display("FAIL reset_modes got %b want 0000", {calib_mode, fmt_mode}); end
  endtask

  task automatic test_run();
    clear_logs();
    push_bytes("r");
    run(12);
    tests++; if (run_cnt !== 1 || run_or !== 2'b01) begin
      fails++; $display("FAIL run_pulse got cnt=%0d bits=%b want cnt=1 bits=01", run_cnt, run_or); end
    tests++; if (pop_cyc.size() != 1 || pulse_cyc.size() != 1 || pulse_cyc[0] - pop_cyc[0] !== 2) begin
      fails++; $display("FAIL run_latency got pops=%0d pulses=%0d want 1 pulse at pop+2", pop_cyc.size(), pulse_cyc.size()); end
    tests++; if (tx_str() != "r") begin fails++; $display("FAIL run_echo got '%s' want 'r'", tx_str()); end
    tests++; if (calib_mode !== 2'b00) begin fails++; $display("FAIL run_calib got %b want 00", calib_mode); end
  endtask

  task automatic test_calib_repeat();
    bit gaps_ok;
    clear_logs();
    push_bytes("C3+");
    run(45);
    gaps_ok = (pulse_cyc.size() == 3) && (pulse_cyc[1] - pulse_cyc[0] == 5) &&
              (pulse_cyc[2] - pulse_cyc[1] == 5);
    tests++; if (calib_mode !== 2'b01) begin fails++; $display("FAIL cal_mode got %b want 01", calib_mode); end
    tests++; if (up_cnt !== 3 || up_or !== 2'b01) begin
      fails++; $display("FAIL rep3_count got cnt=%0d bits=%b want cnt=3 bits=01", up_cnt, up_or); end
    tests++; if (gaps_ok !== 1'b1) begin fails++; $display("FAIL rep3_spacing got %b want 1", gaps_ok); end
    tests++; if (tx_str() != "C3+") begin fails++; $display("FAIL rep3_echo got '%s' want 'C3+'", tx_str()); end
  endtask

  task automatic test_saturate();
    clear_logs();
    push_bytes("25-+");
    run(130);
    tests++; if (down_cnt !== 15) begin fails++; $display("FAIL sat_down got %0d want 15", down_cnt); end
    tests++; if (up_cnt !== 1) begin fails++; $display("FAIL sat_rep_clear got %0d want 1", up_cnt); end
    tests++; if (tx_str() != "25-+") begin fails++; $display("FAIL sat_echo got '%s' want '25-+'", tx_str()); end
  endtask

  task automatic test_channel();
    clear_logs();
    push_bytes("SC+");
    run(30);
    tests++; if (tx_str() != "1C+") begin fails++; $display("FAIL ch_echo got '%s' want '1C+'", tx_str()); end
    tests++; if (calib_mode !== 2'b11) begin fails++; $display("FAIL ch_calib got %b want 11", calib_mode); end
    tests++; if (up_or !== 2'b10 || up_cnt !== 1) begin
      fails++; $display("FAIL ch_up got bits=%b cnt=%0d want bits=10 cnt=1", up_or, up_cnt); end
    tests++; if (ch_sel !== 1'b1) begin fails++; $display("FAIL ch_sel1 got %0d want 1", ch_sel); end
    clear_logs();
    push_bytes("S");
    run(10);
    tests++; if (tx_str() != "0" || ch_sel !== 1'b0) begin
      fails++; $display("FAIL ch_wrap got tx='%s' ch=%0d want tx='0' ch=0", tx_str(), ch_sel); end
  endtask

  task automatic test_illegal();
    clear_logs();
    push_bytes("C+xCr");
    run(40);
    tests++; if (tx_str() != "C??C?") begin fails++; $display("FAIL ill_echo got '%s' want 'C??C?'", tx_str()); end
    tests++; if (pulse_cyc.size() != 0) begin fails++; $display("FAIL ill_pulses got %0d want 0", pulse_cyc.size()); end
    tests++; if (calib_mode !== 2'b11) begin fails++; $display("FAIL ill_calib got %b want 11", calib_mode); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    fifo_tx_full = 1'b1;
    push_bytes("FF");
    run(50);
    tests++; if (pop_cnt !== 1) begin fails++; $display("FAIL bp_pops got %0d want 1", pop_cnt); end
    tests++; if (txq.size() != 0) begin fails++; $display("FAIL bp_push got %0d want 0", txq.size()); end
    tests++; if (fmt_mode !== 2'b01) begin fails++; $display("FAIL bp_fmt got %b want 01", fmt_mode); end
    fifo_tx_full = 1'b0;
    run(20);
    tests++; if (pop_cnt !== 2 || tx_str() != "FF") begin
      fails++; $display("FAIL bp_release got pops=%0d tx='%s' want pops=2 tx='FF'", pop_cnt, tx_str()); end
    tests++; if (fmt_mode !== 2'b00) begin fails++; $display("FAIL bp_fmt_end got %b want 00", fmt_mode); end
  endtask

  task automatic test_reset_midburst();
    int held;
    clear_logs();
    push_bytes("9+");
    for (int i = 0; i < 100 && up_cnt < 2; i++) run(1);
    tests++; if (up_cnt < 2) begin fails++; $display("FAIL mid_burst_start got %0d want >=2", up_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    held = up_cnt;
    tests++; if ({p_run, p_clear, p_up, p_down, p_left, p_right, calib_mode, fmt_mode} !== 16'h0000 ||
                 {fifo_rx_pop, fifo_tx_push, ch_sel} !== 3'b000 || tx_data !== 8'h00) begin
      fails++; $display("FAIL mid_reset_outputs got pulses=%h modes=%b%b want all 0",
                        {p_run, p_clear, p_up, p_down, p_left, p_right}, calib_mode, fmt_mode); end
    run(3);
    rst = 1'b1;
    run(60);
    tests++; if (up_cnt !== held) begin fails++; $display("FAIL mid_reset_stop got %0d want %0d", up_cnt, held); end
  endtask

  task automatic test_onehot();
    tests++; if (viol !== 0) begin fails++; $display("FAIL onehot_violations got %0d want 0", viol); end
  endtask

  initial begin
    rxq.delete();
    fifo_tx_full = 1'b0;
    rst = 1'b0;
    viol = 0;
    clear_logs();
    refresh();
    test_reset();
    test_run();
    test_calib_repeat();
    test_saturate();
    test_channel();
    test_illegal();
    test_backpressure();
    test_reset_midburst();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder_mc.md
Name: uart_cmd_decoder_mc

Overview:
- Multi-channel ASCII command decoder between the UART RX FIFO and the watch/stopwatch cores of the UART dual-watch design.
- Pops bytes from the RX FIFO and turns them into 1-cycle button-equivalent pulses and mode levels on one selected channel; channels are selected at run time with 'S'.
- Adds three things the single-channel decoder lacks: NUM_CH channels, a decimal repeat prefix for adjust commands, and per-byte echo or '?' replies through the TX FIFO.

Parameters:
- NUM_CH, 2, number of controlled channels (1..10).
- REP_MAX, 15, saturation value of the repeat prefix (1..99).
- GAP_CYC, 4, idle cycles between repeated pulses (>=1).
- ECHO_EN, 1, 1 = push a reply byte for every accepted byte; 0 = no TX traffic.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- fifo_rx_empty  in  1  RX FIFO empty; rx_data is valid whenever this is low (show-ahead FIFO).
- rx_data  in  8  RX FIFO head byte.
- fifo_rx_pop  out  1  pop strobe, 1 cycle.
- fifo_tx_full  in  1  TX FIFO full.
- fifo_tx_push  out  1  push strobe, 1 cycle.
- tx_data  out  8  reply byte, valid while fifo_tx_push is high.
- ch_sel  out  max(1,$clog2(NUM_CH))  currently selected channel.
- p_run, p_clear, p_up, p_down, p_left, p_right  out  NUM_CH each  one-hot pulses on bit ch_sel.
- calib_mode  out  NUM_CH  per-channel calibration level.
- fmt_mode  out  NUM_CH  per-channel display-format level.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, ch_sel=0, repeat count cleared, FSM to IDLE. Any in-progress repeat or echo is discarded.
- FSM states:
  - IDLE: if fifo_rx_empty=0, latch rx_data, assert fifo_rx_pop for this cycle, go to DECODE.
  - DECODE: classify the latched byte; go to EMIT, DIGIT or REPLY.
  - EMIT: assert the pulse; decrement rem. If rem>0 go to GAP, else go to REPLY.
  - GAP: wait GAP_CYC cycles, then go to EMIT.
  - DIGIT: rep = min(rep*10 + d, REP_MAX); go to REPLY.
  - REPLY: if ECHO_EN=0 go to IDLE. Otherwise hold until fifo_tx_full=0, assert fifo_tx_push for 1 cycle, go to IDLE.
- Latency: pop at cycle t, first pulse at t+2. Reply is pushed only after the last pulse of the command.
- At most one byte is in flight. No pop occurs while in DECODE, EMIT, GAP, DIGIT or REPLY, so TX backpressure stalls RX consumption.
- Command set (ch = ch_sel):
  - 'r': run pulse; 'c': clear pulse. Legal only when calib_mode[ch]=0.
  - '+', '-', 'L', 'R': up, down, left, right pulses. Legal only when calib_mode[ch]=1.
  - These four are repeatable: rem = (rep==0 ? 1 : rep), so the pulse fires rem times, GAP_CYC+1 cycles apart.
  - 'C': toggle calib_mode[ch]. 'F': toggle fmt_mode[ch]. Both take effect at the EMIT cycle.
  - 'S': ch_sel <= (ch_sel==NUM_CH-1) ? 0 : ch_sel+1.
  - '0'..'9': accumulate into rep; generate no pulse.
- rep is cleared after any non-digit byte, including illegal and unknown bytes.
- A repeat prefix before a non-repeatable command is ignored: the command executes once.
- Reply byte:
  - digit or legal command: echo the received byte;
  - 'S': ASCII '0'+new ch_sel;
  - illegal-in-mode or unknown byte: '?' (8'h3F), with no pulse and no state change.
- Only one pulse output is high in any cycle, on bit ch_sel only.
- Channel state is independent: toggling calib on one channel leaves the others unchanged.
- ch_sel does not change during a repeat burst.

Decomposition:
- Shared package uart_cmd_pkg: ASCII constants (CH_RUN, CH_CLR, CH_UP, CH_DN, CH_L, CH_R, CH_CAL, CH_FMT, CH_SEL, CH_NAK), a command-kind enum, the FSM state enum, and a decode function from byte to command kind.
- One sub-module, cmd_repeat_timer: holds the rem and gap counters, takes load/rem inputs, and produces emit strobes and a done flag.

Test Plan:
- Reset, then 'r' -> p_run[0] high exactly 1 cycle at pop+2; TX receives 'r'; calib_mode=0.
- 'C', then '3', '+' -> calib_mode[0]=1; p_up[0] pulses 3 times, 5 cycles apart (GAP_CYC=4); TX receives 'C','3','+'.
- '2', '5', '-' with REP_MAX=15 -> 15 p_down pulses; a following '+' gives 1 pulse (rep cleared).
- 'S', 'C', '+' -> TX receives '1' for 'S'; calib_mode=2'b11; p_up=2'b10. A second 'S' wraps ch_sel to 0 and TX receives '0'.
- With calib off on ch0: '+' -> no pulse, TX '?'. 'x' -> TX '?'. With calib on: 'r' -> TX '?'.
- fifo_tx_full held high 50 cycles with 2 bytes queued -> exactly 1 pop until full drops. Then rst=0 mid-burst of '9+' -> pulses stop next cycle and all outputs are 0.
